// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: multi-cycle data memory with req/done handshake,
// configurable wait states and word/byte little-endian access.
// Ports:
//   clk, reset (async, active-low)
//   req, we, byte_access, addr, write_data : request, sampled when not busy
//   busy : request in flight (state WAIT)
//   done, fault, read_data : registered completion results
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_access,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] read_data,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, byte_q;
    logic [31:0] addr_q, wdata_q;
    logic        done_q, fault_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept, perform, bad;
    logic [AW-1:0] idx;
    logic [4:0]    lsb;
    logic [31:0]   word, merged;

    assign accept  = req && (state_q != WAIT);
    assign perform = (state_q == WAIT) && (cnt_q == 4'd0);

    // Misaligned word access, or any nonzero index bit above the array.
    assign bad = (!byte_q && (addr_q[1:0] != 2'b00))
               || (addr_q[31:2] >= 30'(DEPTH_WORDS));

    assign idx  = addr_q[AW+1:2];
    assign lsb  = {addr_q[1:0], 3'b000};
    assign word = mem_q[idx];

    always_comb begin
        merged           = word;
        merged[lsb +: 8] = wdata_q[7:0];
    end

    always_comb begin
        rdata_d = rdata_q;
        if (perform) begin
            if (bad || we_q)
                rdata_d = '0;
            else if (byte_q)
                rdata_d = {24'b0, word[lsb +: 8]};
            else
                rdata_d = word;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                else
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= perform;
            fault_q <= perform && bad;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= we;
                byte_q  <= byte_access;
                addr_q  <= addr;
                wdata_q <= write_data;
            end
        end
    end

    // Array is not reset; the write is gated by reset so an access
    // abandoned by reset never lands.
    always_ff @(posedge clk) begin
        if (reset && perform && we_q && !bad)
            mem_q[idx] <= byte_q ? merged : wdata_q;
    end

    assign busy      = (state_q == WAIT);
    assign done      = done_q;
    assign fault     = fault_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench over three data_memory_ctrl
// instances (LATENCY 2 / 0 / 15, the last with DEPTH_WORDS 16).
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [3];
    logic        we  [3];
    logic        ba  [3];
    logic [31:0] addr[3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic        busy[3];
    logic        done[3];
    logic        fault[3];

    int lat  [3] = '{2, 0, 15};
    int ndone[3] = '{0, 0, 0};
    int nexp [3] = '{0, 0, 0};
    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        flt;
        bit          cmp_rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
        .byte_access(ba[0]), .addr(addr[0]), .write_data(wd[0]),
        .busy(busy[0]), .done(done[0]), .read_data(rd[0]),
        .fault(fault[0])
    );

    data_memory_ctrl #(.DEPTH_WORDS(1024), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
        .byte_access(ba[1]), .addr(addr[1]), .write_data(wd[1]),
        .busy(busy[1]), .done(done[1]), .read_data(rd[1]),
        .fault(fault[1])
    );

    data_memory_ctrl #(.DEPTH_WORDS(16), .LATENCY(15)) u2 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]),
        .byte_access(ba[2]), .addr(addr[2]), .write_data(wd[2]),
        .busy(busy[2]), .done(done[2]), .read_data(rd[2]),
        .fault(fault[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input string tag,
                        input logic [31:0] erd, input logic ef,
                        input bit cr);
        exp_t e;
        e = '{tag, erd, ef, cr};
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        nexp[k]++;
    endtask

    task automatic pop(input int k, output exp_t e, output bit have);
        have = 1'b0;
        e    = '{"none", 32'h0, 1'b0, 1'b0};
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default:
               if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
    endtask

    exp_t m_e;
    bit   m_have;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset && done[k]) begin
                ndone[k]++;
                pop(k, m_e, m_have);
                if (!m_have) begin
                    chk("unexp_done", 32'(done[k]), 32'h0);
                end else begin
                    if (m_e.cmp_rd)
                        chk({m_e.tag, "_rd"}, rd[k], m_e.rd);
                    chk({m_e.tag, "_flt"}, 32'(fault[k]), 32'(m_e.flt));
                end
            end
        end
    end

    task automatic access(input int k, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d,
                          input string tag, input logic [31:0] erd,
                          input logic ef);
        int cyc;
        int bcnt;
        @(negedge clk);
        req[k]  = 1'b1;
        we[k]   = w;
        ba[k]   = b;
        addr[k] = a;
        wd[k]   = d;
        push(k, tag, erd, ef, !w || ef);
        @(posedge clk);
        #1 req[k] = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (!done[k] && cyc < 40) begin
            if (busy[k]) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat[k] + 1));
        chk({tag, "_busy"}, 32'(bcnt), 32'(lat[k] + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 0; we[k] = 0; ba[k] = 0; addr[k] = 0; wd[k] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_done", 32'(done[0]), 32'h0);
        chk("rst_flt", 32'(fault[0]), 32'h0);
        chk("rst_rd", rd[0], 32'h0);
        reset = 1'b1;

        // word store / load, byte merge, faults
        access(0, 1, 0, 32'h40, 32'hDEADBEEF, "st_w", 0, 0);
        access(0, 0, 0, 32'h40, 32'h0, "ld_w", 32'hDEADBEEF, 0);
        access(0, 1, 0, 32'h40, 32'h11223344, "st_w2", 0, 0);
        access(0, 1, 1, 32'h41, 32'hFFFFFFAA, "st_b", 0, 0);
        access(0, 0, 0, 32'h40, 32'h0, "ld_mrg", 32'h1122AA44, 0);
        access(0, 0, 1, 32'h43, 32'h0, "ld_b3", 32'h00000011, 0);
        access(0, 0, 1, 32'h41, 32'h0, "ld_b1", 32'h000000AA, 0);
        access(0, 0, 0, 32'h42, 32'h0, "ld_mis", 32'h0, 1);
        access(0, 1, 0, 32'h0, 32'h0BADF00D, "st_w0", 0, 0);
        access(0, 1, 0, 32'h1000, 32'h55555555, "st_oor", 32'h0, 1);
        access(0, 0, 0, 32'h0, 32'h0, "ld_w0", 32'h0BADF00D, 0);

        // request during WAIT is dropped
        @(negedge clk);
        req[0] = 1; we[0] = 0; ba[0] = 0; addr[0] = 32'h40;
        push(0, "drop_ld", 32'h1122AA44, 0, 1);
        @(posedge clk);
        #1 req[0] = 0;
        @(negedge clk);
        req[0] = 1; addr[0] = 32'h0;
        @(posedge clk);
        #1 req[0] = 0;
        repeat (8) @(negedge clk);
        chk("drop_cnt", 32'(ndone[0]), 32'(nexp[0]));

        // reset during WAIT abandons the store
        access(0, 1, 0, 32'h80, 32'h12345678, "st_old", 0, 0);
        @(negedge clk);
        req[0] = 1; we[0] = 1; ba[0] = 0;
        addr[0] = 32'h80; wd[0] = 32'hCAFEF00D;
        @(posedge clk);
        #1 req[0] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy[0]), 32'h0);
        chk("rstw_done", 32'(done[0]), 32'h0);
        @(posedge clk);
        #1 chk("rstw_done2", 32'(done[0]), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        access(0, 0, 0, 32'h80, 32'h0, "ld_old", 32'h12345678, 0);

        // back-to-back with LATENCY 0
        @(negedge clk);
        req[1] = 1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    we[1] = 1; addr[1] = 32'h100; wd[1] = 32'hA5A5A5A5;
                    push(1, "b2b_st0", 0, 0, 0);
                end
                1: begin
                    we[1] = 0; addr[1] = 32'h100; wd[1] = 32'h0;
                    push(1, "b2b_ld0", 32'hA5A5A5A5, 0, 1);
                end
                default: begin
                    we[1] = 1; addr[1] = 32'h104; wd[1] = 32'h5A5A5A5A;
                    push(1, "b2b_st1", 0, 0, 0);
                end
            endcase
            ba[1] = 0;
            n = 0;
            do begin
                @(posedge clk);
                #1 n++;
            end while (!busy[1] && n < 10);
            chk("b2b_gap", 32'(n), (i == 0) ? 32'd1 : 32'd2);
        end
        req[1] = 0;
        repeat (4) @(negedge clk);
        chk("b2b_cnt", 32'(ndone[1]), 32'(nexp[1]));
        access(1, 0, 0, 32'h104, 32'h0, "ld_b2b1", 32'h5A5A5A5A, 0);

        // LATENCY 15, DEPTH 16 boundary
        access(2, 1, 0, 32'h3C, 32'h77665544, "st_top", 0, 0);
        access(2, 0, 0, 32'h3C, 32'h0, "ld_top", 32'h77665544, 0);
        access(2, 0, 0, 32'h40, 32'h0, "ld_over", 32'h0, 1);

        repeat (4) @(negedge clk);
        chk("sb_left", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        for (int k = 0; k < 3; k++)
            chk("done_cnt", 32'(ndone[k]), 32'(nexp[k]));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
